// File: rtl/delta_mod_pkg.sv
// Shared definitions for the multi-channel delta modulator: spike polarity
// encodings and width helpers for the channel id and the queued event word.
package delta_mod_pkg;

  localparam logic SPK_ON  = 1'b1;
  localparam logic SPK_OFF = 1'b0;

  // A single-channel build still needs a 1-bit channel field.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Event word is {channel, polarity}.
  function automatic int evt_width(input int ch_w);
    return ch_w + 1;
  endfunction

endpackage

// File: rtl/delta_mod_multich_fifo.sv
// Synchronous spike event FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module spike_event_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Flags, guarded push/pop and pointer advance.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset discards anything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/delta_mod_multich.sv
// Multi-channel delta modulator. Time-multiplexed samples are compared with
// a per-channel reference; threshold crossings produce ON/OFF events queued
// in a FIFO. Each channel has a refractory window after a spike, and the
// reference can be forced per channel through load_prev.
module delta_mod_multich
  import delta_mod_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NCH        = 4,
  parameter int REFRAC_W   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int STEP_MODE  = 0,
  localparam int CH_W      = ch_width(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W-1:0]   threshold,
  input  logic [REFRAC_W-1:0] refrac_cycles,
  input  logic                off_spike_en,
  input  logic                load_prev,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [DATA_W-1:0]   load_value,
  output logic                spk_valid,
  input  logic                spk_ready,
  output logic [CH_W-1:0]     spk_ch,
  output logic                spk_pol,
  output logic [DATA_W-1:0]   prev_dbg
);

  localparam int EVT_W = evt_width(CH_W);

  logic [DATA_W-1:0]   prev_q   [NCH];
  logic [DATA_W-1:0]   prev_d   [NCH];
  logic [REFRAC_W-1:0] refrac_q [NCH];
  logic [REFRAC_W-1:0] refrac_d [NCH];

  logic                fifo_full;
  logic                fifo_empty;
  logic [EVT_W-1:0]    head_evt;
  logic [EVT_W-1:0]    push_evt;

  logic                accept;
  logic                ch_ok;
  logic                load_hit;
  logic                collide;
  logic [DATA_W-1:0]   prev_sel;
  logic [REFRAC_W-1:0] refrac_sel;
  logic [DATA_W:0]     diff;
  logic [DATA_W:0]     thr_ext;
  logic [DATA_W:0]     up_sum;
  logic                is_on;
  logic                is_off;
  logic                spike;
  logic                pol;
  logic [DATA_W-1:0]   prev_new;

  // Sample compare path: select the channel's state, compute the signed
  // change and decide on an event and the new reference.
  always_comb begin
    in_ready   = ena & ~fifo_full;
    accept     = in_valid & in_ready;
    ch_ok      = ({1'b0, in_ch} < (CH_W+1)'(NCH));
    load_hit   = load_prev & ({1'b0, load_ch} < (CH_W+1)'(NCH));
    collide    = load_hit & (load_ch == in_ch);
    prev_sel   = '0;
    refrac_sel = '0;
    prev_dbg   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (in_ch == CH_W'(i)) begin
        prev_sel   = prev_q[i];
        refrac_sel = refrac_q[i];
      end
      if (load_ch == CH_W'(i)) prev_dbg = prev_q[i];
    end
    diff    = {1'b0, in_data} - {1'b0, prev_sel};
    thr_ext = {1'b0, threshold};
    is_on   = $signed(diff) >= $signed(thr_ext);
    is_off  = off_spike_en & ($signed(diff) <= -$signed(thr_ext));
    spike   = accept & ch_ok & (refrac_sel == '0) & (threshold != '0) &
              ~collide & (is_on | is_off);
    pol     = is_on ? SPK_ON : SPK_OFF;
    up_sum  = {1'b0, prev_sel} + thr_ext;
    if (STEP_MODE != 0) begin
      if (is_on) prev_new = up_sum[DATA_W] ? '1 : up_sum[DATA_W-1:0];
      else       prev_new = (prev_sel < threshold) ? '0 : prev_sel - threshold;
    end else begin
      prev_new = in_data;
    end
    push_evt = {in_ch, pol};
  end

  // Per-channel next state: refractory countdown, spike update, then the
  // forced load, which overrides everything for its channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      prev_d[i]   = prev_q[i];
      refrac_d[i] = refrac_q[i];
      if (ena && (refrac_q[i] != '0)) refrac_d[i] = refrac_q[i] - REFRAC_W'(1);
      if (spike && (in_ch == CH_W'(i))) begin
        prev_d[i]   = prev_new;
        refrac_d[i] = refrac_cycles;
      end
      if (load_hit && (load_ch == CH_W'(i))) begin
        prev_d[i]   = load_value;
        refrac_d[i] = '0;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        prev_q[i]   <= '0;
        refrac_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        prev_q[i]   <= prev_d[i];
        refrac_q[i] <= refrac_d[i];
      end
    end
  end

  spike_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (spike),
    .push_data (push_evt),
    .pop       (spk_ready),
    .pop_data  (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head presentation; fields read zero whenever nothing is queued.
  always_comb begin
    spk_valid = ~fifo_empty;
    spk_ch    = fifo_empty ? '0 : head_evt[EVT_W-1:1];
    spk_pol   = fifo_empty ? 1'b0 : head_evt[0];
  end

endmodule
